// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RV32I data memory responder
// with fixed response latency, lane-masked stores and extended loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [IW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          t_we;
  logic [IW-1:0] t_addr;
  logic [31:0]   t_wdata;
  logic [2:0]    t_f3;
  logic          t_err;
  logic [AW-1:0] t_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic [3:0]    wmask;
  logic [31:0]   wlane;
  logic          accept;
  logic          enter_resp;
  logic          wr_en;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:IW];

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

  // Transaction source: live inputs when committing on the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      t_we    = req_we;
      t_addr  = req_addr[IW-1:0];
      t_wdata = req_wdata;
      t_f3    = req_funct3;
    end else begin
      t_we    = we_q;
      t_addr  = addr_q;
      t_wdata = wdata_q;
      t_f3    = f3_q;
    end
  end

  assign t_idx = t_addr[IW-1:2];

  // Legality and alignment decode.
  always_comb begin
    t_err = 1'b1;
    unique case (1'b1)
      t_f3 == 3'b000: t_err = 1'b0;
      t_f3 == 3'b001: t_err = t_addr[0];
      t_f3 == 3'b010: t_err = |t_addr[1:0];
      t_f3 == 3'b100: t_err = t_we;
      t_f3 == 3'b101: t_err = t_we | t_addr[0];
      default:        t_err = 1'b1;
    endcase
  end

  assign rd_word  = mem_q[t_idx];
  assign rd_shift = rd_word >> {t_addr[1:0], 3'b000};
  assign rd_half  = t_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Load lane extraction and extension.
  always_comb begin
    ld_data = rd_word;
    unique case (1'b1)
      t_f3 == 3'b000: ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      t_f3 == 3'b001: ld_data = {{16{rd_half[15]}}, rd_half};
      t_f3 == 3'b100: ld_data = {24'h0, rd_shift[7:0]};
      t_f3 == 3'b101: ld_data = {16'h0, rd_half};
      default:        ld_data = rd_word;
    endcase
  end

  // Store lane masks and replicated write data.
  always_comb begin
    wmask = 4'b1111;
    wlane = t_wdata;
    unique case (1'b1)
      t_f3[1:0] == 2'b00: begin
        wmask = 4'b0001 << t_addr[1:0];
        wlane = {4{t_wdata[7:0]}};
      end
      t_f3[1:0] == 2'b01: begin
        wmask = t_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{t_wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wlane = t_wdata;
      end
    endcase
  end

  assign enter_resp = (accept && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q <= 4'd1));
  assign wr_en = rst_n & enter_resp & t_we & ~t_err;

  // Storage: no reset, so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem_q[t_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Next-state, capture and response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[IW-1:0];
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (t_we || t_err) ? 32'h0 : ld_data;
      err_d   = t_err;
    end
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed checks of dmem_responder
// against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem_b [4*DEPTH];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] rd, output logic er);
    int a, sz;
    longint v;
    a  = int'(addr % 32'(4 * DEPTH));
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er = (f3[1:0] == 2'b11) || (f3[2] && f3[1]) || (we && f3[2]) ||
         ((a % sz) != 0);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < sz; i++) mem_b[a+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v += longint'(mem_b[a+i]) << (8 * i);
      if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
        v -= longint'(1) << (8 * sz);
      rd = v[31:0];
    end
  endfunction

  task automatic xact(input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input int hold, output logic [31:0] got);
    logic [31:0] exp_rd, r0;
    logic exp_er, e0;
    int cyc;
    model(we, addr, wd, f3, exp_rd, exp_er);
    got = 32'h0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_funct3 = f3;
    rsp_ready  = 1'b0;
    check("req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    cyc = 1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    while (!rsp_valid && cyc < 40) begin
      check("rdata_idle", rsp_rdata, 32'h0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LAT));
    if (!rsp_valid) return;
    r0  = rsp_rdata;
    e0  = rsp_err;
    got = r0;
    check("rdata", r0, exp_rd);
    check("err", {31'b0, e0}, {31'b0, exp_er});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, r0);
      check("hold_err", {31'b0, rsp_err}, {31'b0, e0});
      check("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rel_valid", {31'b0, rsp_valid}, 32'd0);
    check("rel_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] got, a, d, er_rd;
    logic er;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      xact(1'b1, 32'(i * 4), $urandom, 3'b010, 0, got);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, got);
    check("st_w_rdata", got, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 1, got);
    check("ld_w", got, 32'hDEADBEEF);
    xact(1'b1, 32'h13, 32'h80, 3'b000, 0, got);
    xact(1'b0, 32'h13, 32'h0, 3'b000, 0, got);
    check("ld_b", got, 32'hFFFFFF80);
    xact(1'b0, 32'h13, 32'h0, 3'b100, 0, got);
    check("ld_bu", got, 32'h00000080);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 0, got);
    check("ld_w_merge", got, 32'h80ADBEEF);
    xact(1'b0, 32'h11, 32'h0, 3'b001, 0, got);
    check("ld_h_mis", got, 32'h0);
    xact(1'b1, 32'h22, 32'hCAFEF00D, 3'b010, 0, got);
    xact(1'b0, 32'h20, 32'h0, 3'b010, 0, got);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 5, got);
    check("hold5", got, 32'h80ADBEEF);
    xact(1'b1, 32'h400, 32'h12345678, 3'b010, 0, got);
    xact(1'b0, 32'h0, 32'h0, 3'b010, 0, got);
    check("wrap", got, 32'h12345678);

    // Reset while the store waits: store must be dropped.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h40;
    req_wdata  = 32'hA5A5A5A5;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("wrst_valid", {31'b0, rsp_valid}, 32'd0);
    check("wrst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("wrst_novalid", {31'b0, rsp_valid}, 32'd0);
    end
    xact(1'b0, 32'h40, 32'h0, 3'b010, 0, got);

    // Reset during the response: store already committed.
    model(1'b1, 32'h44, 32'h5A5A1234, 3'b010, er_rd, er);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h44;
    req_wdata  = 32'h5A5A1234;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rrst_pre", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rrst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rrst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h44, 32'h0, 3'b010, 0, got);
    check("rrst_keep", got, 32'h5A5A1234);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom;
      xact(1'($urandom_range(0, 1)), a, d, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit storage words; it SHALL be a power of two, >= 4.
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request accept to rsp_valid; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid  input  1  SHALL indicate that a load/store request is presented.
REQ-006 req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 req_we  input  1  SHALL select a store (1) or a load (0).
REQ-008 req_addr  input  32  SHALL carry the byte address (core ALU result).
REQ-009 req_wdata  input  32  SHALL carry the store data (core rs2 value), taken from the low lanes.
REQ-010 req_funct3  input  3  SHALL carry the RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rsp_valid  output  1  SHALL indicate that the response is valid.
REQ-012 rsp_ready  input  1  SHALL indicate that the requester takes the response.
REQ-013 rsp_rdata  output  32  SHALL carry the load data, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  SHALL flag a misaligned or illegal request.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid & req_ready are both 1.
REQ-017 On accept, the block SHALL capture req_we, req_addr, req_wdata and req_funct3; later input changes SHALL have no effect on the transaction.
REQ-018 On accept, the FSM SHALL go to RESP if LATENCY==1; otherwise it SHALL go to WAIT and load a counter with LATENCY-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 1 the FSM SHALL go to RESP, so rsp_valid is first high exactly LATENCY cycles after the accept edge.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL hold stable until rsp_valid & rsp_ready; that edge SHALL return the FSM to IDLE.
REQ-021 Only one request SHALL be outstanding; a back-to-back request has at least one idle cycle with req_ready=1 after the response handshake.
REQ-022 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 Error conditions, each of which SHALL set rsp_err=1, suppress any write and give rsp_rdata=0:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=00;
  - a load with funct3 in {011, 110, 111};
  - a store with funct3 not in {000, 001, 010}.
REQ-024 A store SHALL commit on the edge entering RESP, writing only the addressed lanes:
  - B: wdata[7:0] to byte addr[1:0];
  - H: wdata[15:0] to half addr[1];
  - W: all 32 bits.
REQ-025 A load SHALL read storage on the edge entering RESP and shift the addressed lane to bit 0:
  - B and H SHALL be sign-extended;
  - BU and HU SHALL be zero-extended;
  - W SHALL pass through.
REQ-026 Storage SHALL NOT be initialised by reset; contents written before a reset SHALL persist across it.
REQ-027 A load to the same address as the preceding store SHALL return the stored data (no stale read).
REQ-028 rsp_rdata SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-029 While rst_n=0 at an edge, the FSM SHALL go to IDLE, the counter SHALL clear, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=1 after that edge.
REQ-030 A reset in WAIT SHALL abort the transaction; an uncommitted store SHALL NOT modify storage, and no response SHALL follow.
REQ-031 A reset in RESP SHALL drop rsp_valid on the next edge, and the committed store SHALL remain.

Verification
REQ-032 LATENCY=2: store W addr 0x10 data 0xDEADBEEF accepted at cycle 0 -> rsp_valid=1 at cycle 2 with rsp_err=0 and rsp_rdata=0; a following load W 0x10 -> 0xDEADBEEF.
REQ-033 Store B addr 0x13 data 0x80, then load B 0x13 -> 0xFFFFFF80; load BU 0x13 -> 0x00000080; load W 0x10 -> 0x80ADBEEF.
REQ-034 Load H addr 0x11 -> rsp_err=1 and rsp_rdata=0; store W addr 0x22 -> rsp_err=1 and storage is unchanged on readback.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stay stable and req_ready=0; raising rsp_ready -> IDLE on the next edge.
REQ-036 With DEPTH_WORDS=256, store W addr 0x400 data 0x12345678 -> a load W addr 0x0 returns 0x12345678 (wrap).
REQ-037 Store accepted, rst_n=0 at the next edge (WAIT), then a load of the same address -> old data, with no rsp_valid during or after the reset.
